// File: rtl/expr_sig_capture.sv
// expr_sig_capture
//   Captures a run of 90-bit result vectors from an upstream expression stage
//   and compresses them into a 32-bit MISR signature (CRC-32 polynomial).
//   It also counts accepted samples and how many differed from their
//   predecessor.
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   rst          : synchronous active-high reset
//   start        : begin a run (honoured only in IDLE or DONE)
//   num_samples  : run length, latched when start is accepted
//   y_in         : 90-bit sample from upstream
//   in_valid     : y_in is valid this cycle
//   in_ready     : block accepts y_in this cycle (high in RUN)
//   busy         : high in RUN
//   done         : high in DONE
//   signature    : current MISR value
//   sample_count : samples accepted this run
//   change_count : accepted samples that differed from the previous one
//                  (saturating)
module expr_sig_capture (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] num_samples,
  input  logic [89:0] y_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] signature,
  output logic [15:0] sample_count,
  output logic [15:0] change_count
);

  localparam logic [31:0] SEED = 32'hFFFF_FFFF;
  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] sig_q, sig_d;
  logic [15:0] sample_cnt_q, sample_cnt_d;
  logic [15:0] change_cnt_q, change_cnt_d;
  logic [15:0] len_q, len_d;
  logic [89:0] prev_y_q, prev_y_d;

  logic        handshake;
  logic [31:0] fold;
  logic [31:0] sig_step;

  assign handshake = in_valid && (state_q == RUN);

  // Fold the 90-bit sample into 32 bits before feeding the MISR.
  assign fold     = y_in[31:0] ^ y_in[63:32] ^ {6'b0, y_in[89:64]};
  assign sig_step = ({sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : 32'h0)) ^ fold;

  always_comb begin
    state_d      = state_q;
    sig_d        = sig_q;
    sample_cnt_d = sample_cnt_q;
    change_cnt_d = change_cnt_q;
    len_d        = len_q;
    prev_y_d     = prev_y_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sig_d        = SEED;
          sample_cnt_d = 16'd0;
          change_cnt_d = 16'd0;
          len_d        = num_samples;
          state_d      = (num_samples != 16'd0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (handshake) begin
          sig_d        = sig_step;
          sample_cnt_d = sample_cnt_q + 16'd1;
          prev_y_d     = y_in;
          // sample_cnt_q == 0 marks the first sample of the run, which has
          // no predecessor to compare against.
          if ((sample_cnt_q != 16'd0) && (y_in != prev_y_q) &&
              (change_cnt_q != 16'hFFFF)) begin
            change_cnt_d = change_cnt_q + 16'd1;
          end
          if ((sample_cnt_q + 16'd1) == len_q) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sig_q        <= SEED;
      sample_cnt_q <= 16'd0;
      change_cnt_q <= 16'd0;
      len_q        <= 16'd0;
      prev_y_q     <= 90'd0;
    end else begin
      state_q      <= state_d;
      sig_q        <= sig_d;
      sample_cnt_q <= sample_cnt_d;
      change_cnt_q <= change_cnt_d;
      len_q        <= len_d;
      prev_y_q     <= prev_y_d;
    end
  end

  assign in_ready     = (state_q == RUN);
  assign busy         = (state_q == RUN);
  assign done         = (state_q == DONE);
  assign signature    = sig_q;
  assign sample_count = sample_cnt_q;
  assign change_count = change_cnt_q;

endmodule
